// File: rtl/dcache_ctrl_pkg.sv
// Shared types and constants for the data-cache miss controller.
package dcache_ctrl_pkg;

  // Miss-handling FSM states.
  typedef enum logic [1:0] {
    DC_IDLE,
    DC_WB,
    DC_FILL,
    DC_RETRY
  } dc_state_t;

  localparam int DC_LINE_WORDS = 4;
  localparam int DC_WORD_OFS_W = 2;

endpackage

// File: rtl/dcache_ctrl_sat_cnt.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module dcache_ctrl_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count events, stopping at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache miss controller: write-back of dirty victims, line fill from
// unified memory one word per beat, pipeline stall via d_rdy.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int INDEX_W    = 6,
  parameter int MISS_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  input  logic [12:0]           cpu_addr,
  input  logic [15:0]           cpu_wdata,
  output logic                  d_rdy,
  input  logic                  c_hit,
  input  logic                  c_dirty,
  input  logic [10-INDEX_W:0]   c_tag,
  input  logic [15:0]           c_rdata,
  output logic [12:0]           c_addr,
  output logic                  c_we,
  output logic [15:0]           c_wdata,
  output logic                  c_wdirty,
  output logic                  c_fill,
  output logic [12:0]           mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_rdy,
  output logic [MISS_CNT_W-1:0] miss_cnt,
  output logic [MISS_CNT_W-1:0] wb_cnt
);

  localparam int TAG_W = 11 - INDEX_W;
  localparam logic [DC_WORD_OFS_W-1:0] LAST_BEAT = DC_WORD_OFS_W'(DC_LINE_WORDS - 1);

  dc_state_t                 state_q, state_d;
  logic [DC_WORD_OFS_W-1:0]  beat_q, beat_d;
  logic [10:0]               line_q;
  logic [TAG_W-1:0]          tag_q;
  logic                      acc;
  logic                      latch;
  logic                      miss_inc;
  logic                      wb_inc;

  assign acc = cpu_re | cpu_we;

  // State and beat counter; reset returns to IDLE and abandons any line in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DC_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Capture the missing line and the victim tag at miss detection; held until the next miss.
  always_ff @(posedge clk) begin
    if (latch) begin
      line_q <= cpu_addr[12:2];
      tag_q  <= c_tag;
    end
  end

  // Next state and all cache/memory outputs.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    d_rdy     = 1'b0;
    c_addr    = cpu_addr;
    c_we      = 1'b0;
    c_wdata   = cpu_wdata;
    c_wdirty  = 1'b0;
    c_fill    = 1'b0;
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    latch     = 1'b0;
    miss_inc  = 1'b0;
    wb_inc    = 1'b0;
    case (state_q)
      DC_IDLE: begin
        d_rdy = ~acc | c_hit;
        if (acc && c_hit) begin
          // A store that hits marks the line dirty; a load needs nothing written.
          c_we     = cpu_we;
          c_wdirty = cpu_we;
        end else if (acc) begin
          latch    = 1'b1;
          miss_inc = 1'b1;
          wb_inc   = c_dirty;
          beat_d   = '0;
          state_d  = c_dirty ? DC_WB : DC_FILL;
        end
      end
      DC_WB: begin
        // Victim word is read combinationally from the cache and forwarded the same cycle.
        c_addr    = {line_q, beat_q};
        mem_we    = 1'b1;
        mem_addr  = {tag_q, line_q[INDEX_W-1:0], beat_q};
        mem_wdata = c_rdata;
        if (mem_rdy) begin
          beat_d = beat_q + DC_WORD_OFS_W'(1);
          if (beat_q == LAST_BEAT) state_d = DC_FILL;
        end
      end
      DC_FILL: begin
        mem_re   = 1'b1;
        mem_addr = {line_q, beat_q};
        c_addr   = {line_q, beat_q};
        if (mem_rdy) begin
          c_we    = 1'b1;
          c_fill  = 1'b1;
          c_wdata = mem_rdata;
          beat_d  = beat_q + DC_WORD_OFS_W'(1);
          if (beat_q == LAST_BEAT) state_d = DC_RETRY;
        end
      end
      DC_RETRY: begin
        // One bubble so the freshly filled tag is visible to the lookup.
        state_d = DC_IDLE;
      end
      default: begin
        state_d = DC_IDLE;
      end
    endcase
  end

  dcache_ctrl_sat_cnt #(.W(MISS_CNT_W)) u_miss_cnt (
    .clk (clk),
    .clr (~rst_n),
    .inc (miss_inc),
    .cnt (miss_cnt)
  );

  dcache_ctrl_sat_cnt #(.W(MISS_CNT_W)) u_wb_cnt (
    .clk (clk),
    .clr (~rst_n),
    .inc (wb_inc),
    .cnt (wb_cnt)
  );

endmodule
